// File: rtl/iomem_timer_pkg.sv
// Shared constants for the iomem timer: register offsets, CTRL/STATUS bit positions
// and the byte-lane merge used by every writable register.
package iomem_timer_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LOAD   = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned CTRL_PRESC_LSB   = 8;

  localparam int unsigned STATUS_EXPIRED = 0;

  function automatic logic [31:0] merge_wstrb(logic [31:0] old_val, logic [31:0] wdata,
                                              logic [3:0] wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// SoC iomem bus: valid/ready handshake with byte strobes; wstrb == 0 means read.
interface iomem_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_timer_prescaler.sv
// Clock prescaler: one tick every presc+1 cycles while enabled, counter held at 0 otherwise.
module iomem_timer_prescaler #(
  parameter int unsigned PRESC_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESC_BITS-1:0] presc,
  output logic                  tick
);

  logic [PRESC_BITS-1:0] pcnt_q;

  assign tick = en && (pcnt_q == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (!en || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESC_BITS'(1);
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// 32-bit down-counting timer on the iomem bus: 16-byte register window, one wait state,
// periodic or one-shot expiry driving a level interrupt.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned PRESC_BITS = 8
) (
  input  logic         clk,
  input  logic         reset,
  iomem_timer_if.slave bus,
  output logic         irq
);

  logic                  ready_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  en_q, en_d, auto_q, auto_d, irq_en_q, irq_en_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [31:0]           load_q, load_d, count_q, count_d;
  logic                  expired_q, expired_d;

  logic        sel, acc, wr, tick, expire;
  logic [3:0]  off;
  logic [31:0] ctrl_rd, ctrl_wr, rd_mux;
  logic        unused_bits;

  assign sel    = bus.iomem_valid && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign acc    = sel && !ready_q;
  assign wr     = acc && (bus.iomem_wstrb != 4'b0000);
  assign off    = {bus.iomem_addr[3:2], 2'b00};
  assign expire = tick && (count_q == '0);

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq             = expired_q & irq_en_q;
  assign unused_bits     = ^{bus.iomem_addr[1:0], ctrl_wr};

  iomem_timer_prescaler #(
    .PRESC_BITS(PRESC_BITS)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en_q),
    .presc(presc_q),
    .tick (tick)
  );

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN]          = en_q;
    ctrl_rd[CTRL_AUTO_RELOAD] = auto_q;
    ctrl_rd[CTRL_IRQ_EN]      = irq_en_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_BITS] = presc_q;
    ctrl_wr = merge_wstrb(ctrl_rd, bus.iomem_wdata, bus.iomem_wstrb);

    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux = ctrl_rd;
      OFF_LOAD:   rd_mux = load_q;
      OFF_COUNT:  rd_mux = count_q;
      OFF_STATUS: rd_mux[STATUS_EXPIRED] = expired_q;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    irq_en_d  = irq_en_q;
    presc_d   = presc_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (auto_q) count_d = load_q;
        else        en_d    = 1'b0;
      end
    end

    // Bus writes are applied last so they win over same-cycle tick effects.
    if (wr) begin
      case (off)
        OFF_CTRL: begin
          en_d     = ctrl_wr[CTRL_EN];
          auto_d   = ctrl_wr[CTRL_AUTO_RELOAD];
          irq_en_d = ctrl_wr[CTRL_IRQ_EN];
          presc_d  = ctrl_wr[CTRL_PRESC_LSB +: PRESC_BITS];
        end
        OFF_LOAD:  load_d  = merge_wstrb(load_q, bus.iomem_wdata, bus.iomem_wstrb);
        OFF_COUNT: count_d = merge_wstrb(count_q, bus.iomem_wdata, bus.iomem_wstrb);
        OFF_STATUS: begin
          // A fresh expiry on this cycle must survive the clear.
          if (bus.iomem_wstrb[0] && bus.iomem_wdata[STATUS_EXPIRED] && !expire) begin
            expired_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    rdata_d = acc ? rd_mux : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      presc_q   <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ready_q   <= acc;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      irq_en_q  <= irq_en_d;
      presc_q   <= presc_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: expiry times and register contents are predicted
// arithmetically from the register-level behaviour, with randomized counts and strobes.
module tb_iomem_timer;

  localparam logic [31:0] BASE     = 32'h0300_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_LOAD   = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  int unsigned cycle = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] last_rdata;
  int          last_lat;

  iomem_timer_if bif ();

  iomem_timer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Starts on the next edge; returns 1 time unit after the edge that acknowledged.
  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(posedge clk);
    #1;
    bif.iomem_valid = 1'b1;
    bif.iomem_addr  = a;
    bif.iomem_wstrb = s;
    bif.iomem_wdata = d;
    last_lat = 0;
    do begin
      @(posedge clk);
      #1;
      last_lat++;
    end while (!bif.iomem_ready && last_lat < 6);
    last_rdata = bif.iomem_rdata;
    bif.iomem_valid = 1'b0;
    bif.iomem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_xfer(a, 4'hF, d);
  endtask

  task automatic rd(input logic [31:0] a);
    bus_xfer(a, 4'h0, 32'h0);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cycle < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input int unsigned limit);
    while (!irq && cycle < limit) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_zero;
    exp_zero = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bif.iomem_ready !== 1'b0 || bif.iomem_rdata !== exp_zero || irq !== 1'b0) begin
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, required 0/0/0",
               bif.iomem_ready, bif.iomem_rdata, irq);
    end else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i));
      n_total++;
      if (last_rdata !== exp_zero || last_lat != 1) begin
        $display("FAIL reset_read[%0d]: rdata=%h lat=%0d, required 00000000 lat=1",
                 i, last_rdata, last_lat);
      end else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: irq=%b, required 0", irq);
    else n_pass++;

    // Valid held past the ack: ready must still last exactly one cycle.
    @(posedge clk);
    #1;
    bif.iomem_valid = 1'b1;
    bif.iomem_addr  = A_STATUS;
    bif.iomem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    n_total++;
    if (bif.iomem_ready !== 1'b1) $display("FAIL ready_rise: ready=%b, required 1", bif.iomem_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bif.iomem_ready !== 1'b0) $display("FAIL ready_one_cycle: ready=%b, required 0",
                                           bif.iomem_ready);
    else n_pass++;
    bif.iomem_valid = 1'b0;

    // Reset in the middle of an access drops ready without waiting for a clock edge.
    @(posedge clk);
    #1;
    bif.iomem_valid = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (bif.iomem_ready !== 1'b0) $display("FAIL reset_mid_access: ready=%b, required 0",
                                           bif.iomem_ready);
    else n_pass++;
    bif.iomem_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_periodic();
    int unsigned t0, t_exp, e;
    int          exp_cnt;
    wr(A_LOAD, 32'd5);
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h0000_0307);
    t0 = cycle;
    n_total++;
    if (irq !== 1'b0) $display("FAIL periodic_irq_idle: irq=%b, required 0", irq);
    else n_pass++;
    wait_irq(t0 + 40);
    n_total++;
    if (cycle - t0 != 24) $display("FAIL periodic_first: delay=%0d, required 24", cycle - t0);
    else n_pass++;
    t_exp = cycle;
    for (int k = 0; k < 2; k++) begin
      wr(A_STATUS, 32'h1);
      n_total++;
      if (irq !== 1'b0) $display("FAIL periodic_clear[%0d]: irq=%b, required 0", k, irq);
      else n_pass++;
      rd(A_COUNT);
      e = cycle;
      exp_cnt = 5 - int'((e - 1 - t_exp) / 4);
      n_total++;
      if (last_rdata !== 32'(exp_cnt)) begin
        $display("FAIL periodic_count[%0d]: COUNT=%0d, required %0d", k, last_rdata, exp_cnt);
      end else n_pass++;
      wait_irq(t_exp + 40);
      n_total++;
      if (cycle - t_exp != 24) begin
        $display("FAIL periodic_period[%0d]: period=%0d, required 24", k, cycle - t_exp);
      end else n_pass++;
      t_exp = cycle;
    end
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_one_shot();
    int unsigned t0, n, p, k;
    logic        saw_irq;
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h0000_0001);
    saw_irq = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (irq) saw_irq = 1'b1;
    end
    n_total++;
    if (saw_irq !== 1'b0) $display("FAIL oneshot_no_irq: irq seen=%b, required 0", saw_irq);
    else n_pass++;
    rd(A_CTRL);
    n_total++;
    if (last_rdata !== 32'h0) $display("FAIL oneshot_ctrl: CTRL=%h, required 00000000", last_rdata);
    else n_pass++;
    rd(A_COUNT);
    n_total++;
    if (last_rdata !== 32'h0) $display("FAIL oneshot_count: COUNT=%h, required 0", last_rdata);
    else n_pass++;
    rd(A_STATUS);
    n_total++;
    if (last_rdata !== 32'h1) $display("FAIL oneshot_status: STATUS=%h, required 1", last_rdata);
    else n_pass++;

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 12);
      p = $urandom_range(0, 3);
      k = (n + 1) * (p + 1);
      wr(A_CTRL, 32'h0);
      wr(A_STATUS, 32'h1);
      wr(A_COUNT, n);
      wr(A_CTRL, (p << 8) | 32'h5);
      t0 = cycle;
      wait_irq(t0 + k + 8);
      n_total++;
      if (cycle - t0 != k) begin
        $display("FAIL oneshot_delay[%0d] N=%0d P=%0d: delay=%0d, required %0d",
                 i, n, p, cycle - t0, k);
      end else n_pass++;
      rd(A_CTRL);
      n_total++;
      if (last_rdata !== ((p << 8) | 32'h4)) begin
        $display("FAIL oneshot_stop[%0d]: CTRL=%h, required %h", i, last_rdata, (p << 8) | 32'h4);
      end else n_pass++;
      rd(A_COUNT);
      n_total++;
      if (last_rdata !== 32'h0) $display("FAIL oneshot_hold[%0d]: COUNT=%h, required 0",
                                         i, last_rdata);
      else n_pass++;
    end
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_byte_strobes();
    logic [31:0] old_v, new_v, mask, expv;
    logic [3:0]  s;
    wr(A_LOAD, 32'h0);
    bus_xfer(A_LOAD, 4'b0101, 32'hAABB_CCDD);
    rd(A_LOAD);
    n_total++;
    if (last_rdata !== 32'h00BB_00DD) begin
      $display("FAIL strobe_fixed: LOAD=%h, required 00BB00DD", last_rdata);
    end else n_pass++;
    for (int i = 0; i < 6; i++) begin
      old_v = $urandom;
      new_v = $urandom;
      s     = 4'($urandom_range(1, 15));
      mask  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      expv  = (old_v & ~mask) | (new_v & mask);
      wr(A_LOAD, old_v);
      bus_xfer(A_LOAD, s, new_v);
      rd(A_LOAD);
      n_total++;
      if (last_rdata !== expv) begin
        $display("FAIL strobe_rand[%0d] wstrb=%b: LOAD=%h, required %h", i, s, last_rdata, expv);
      end else n_pass++;
    end
  endtask

  task automatic test_collision();
    int unsigned a;
    // One-shot COUNT=3, presc=0: expiry lands on the edge 4 cycles after the CTRL ack.
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h1);
    a = cycle;
    wait_until(a + 2);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS);
    n_total++;
    if (last_rdata !== 32'h1) $display("FAIL w1c_vs_expiry: STATUS=%h, required 1", last_rdata);
    else n_pass++;
    wr(A_STATUS, 32'h1);
    rd(A_STATUS);
    n_total++;
    if (last_rdata !== 32'h0) $display("FAIL w1c_plain: STATUS=%h, required 0", last_rdata);
    else n_pass++;

    // Auto-reload, presc=3: ticks land every 4 cycles after the CTRL ack.
    wr(A_LOAD, 32'd100);
    wr(A_COUNT, 32'd50);
    wr(A_CTRL, 32'h0000_0303);
    a = cycle;
    wait_until(a + 6);
    wr(A_COUNT, 32'd777);
    rd(A_COUNT);
    n_total++;
    if (last_rdata !== 32'd777) begin
      $display("FAIL count_write_vs_tick: COUNT=%0d, required 777", last_rdata);
    end else n_pass++;
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs[4];
    logic        bad;
    wr(A_LOAD, 32'h1357_9BDF);
    addrs[0] = 32'h0300_0010;
    addrs[1] = 32'h0200_0004;
    for (int i = 2; i < 4; i++) begin
      addrs[i] = $urandom;
      if (addrs[i][31:4] == 28'h030_0000) addrs[i][31] = ~addrs[i][31];
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bif.iomem_valid = 1'b1;
      bif.iomem_addr  = addrs[i];
      bif.iomem_wstrb = 4'hF;
      bif.iomem_wdata = 32'hFFFF_FFFF;
      bad = 1'b0;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (bif.iomem_ready !== 1'b0 || bif.iomem_rdata !== 32'h0) bad = 1'b1;
      end
      bif.iomem_valid = 1'b0;
      bif.iomem_wstrb = 4'h0;
      n_total++;
      if (bad !== 1'b0) $display("FAIL outside_window[%h]: responded=%b, required 0", addrs[i], bad);
      else n_pass++;
    end
    rd(A_LOAD);
    n_total++;
    if (last_rdata !== 32'h1357_9BDF) begin
      $display("FAIL outside_no_write: LOAD=%h, required 13579BDF", last_rdata);
    end else n_pass++;
  endtask

  initial begin
    bif.iomem_valid = 1'b0;
    bif.iomem_addr  = 32'h0;
    bif.iomem_wstrb = 4'h0;
    bif.iomem_wdata = 32'h0;
    last_rdata      = 32'h0;
    last_lat        = 0;
    test_reset();
    test_periodic();
    test_one_shot();
    test_byte_strobes();
    test_collision();
    test_out_of_window();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
